// File: rtl/onehot_index_decoder.sv
// onehot_index_decoder: turns encoded indices (plus a "no request" flag) back
// into timed one-hot strobes. Words arrive through a valid/ready handshake
// into a 2-entry FIFO. An IDLE/DRIVE/GAP FSM then drives each strobe for HOLD
// cycles and follows it with GAP forced idle cycles.
module onehot_index_decoder #(
    parameter int IDX_W = 2,
    parameter int HOLD  = 1,
    parameter int GAP   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      in_idx,
    input  logic                  in_none,
    output logic [2**IDX_W-1:0]   out_onehot,
    output logic                  out_valid,
    output logic                  busy,
    output logic [7:0]            pulse_count
);

    localparam int OUT_W    = 2**IDX_W;
    // A HOLD of 0 would give an empty window; run it as a 1-cycle window.
    localparam int HOLD_EFF = (HOLD < 1) ? 1 : HOLD;
    localparam int CNT_MAX  = (HOLD_EFF > GAP) ? HOLD_EFF : GAP;
    // hcnt only counts down from CNT_MAX-1, so $clog2(CNT_MAX) bits suffice.
    localparam int CNT_W    = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // ---------------------------------------------------------------
    // 2-entry FIFO of {none, idx} words
    // ---------------------------------------------------------------
    logic [IDX_W:0] mem_reg [2];
    logic           wr_ptr_reg;
    logic           rd_ptr_reg;
    logic [1:0]     count_reg;
    logic           push;
    logic           pop;
    logic           fifo_empty;
    logic [IDX_W:0] head;
    logic           head_none;
    logic [IDX_W-1:0] head_idx;
    logic [OUT_W-1:0] head_onehot;

    // Ready comes only from the registered count, so a full FIFO does not
    // accept a word even in a cycle where it pops one.
    assign in_ready   = !rst && (count_reg < 2'd2);
    assign push       = in_valid && in_ready;
    assign fifo_empty = (count_reg == 2'd0);
    assign head       = mem_reg[rd_ptr_reg];
    assign head_none  = head[IDX_W];
    assign head_idx   = head[IDX_W-1:0];

    // FIFO storage write; the contents need no reset because count guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= {in_none, in_idx};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // One decoder line per output bit; a "none" word lights no line.
    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_decode
        assign head_onehot[gi] = !head_none && (head_idx == IDX_W'(gi));
    end

    // ---------------------------------------------------------------
    // Strobe timing FSM
    // ---------------------------------------------------------------
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  hcnt_reg, hcnt_next;
    logic [OUT_W-1:0]  onehot_reg, onehot_next;
    logic              valid_reg, valid_next;
    logic [7:0]        pc_reg, pc_next;

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            hcnt_reg   <= '0;
            onehot_reg <= '0;
            valid_reg  <= 1'b0;
            pc_reg     <= 8'd0;
        end else begin
            state_reg  <= state_next;
            hcnt_reg   <= hcnt_next;
            onehot_reg <= onehot_next;
            valid_reg  <= valid_next;
            pc_reg     <= pc_next;
        end
    end

    // Next-state logic: start, hold, end and gap of each strobe window.
    always_comb begin
        state_next  = state_reg;
        hcnt_next   = hcnt_reg;
        onehot_next = onehot_reg;
        valid_next  = valid_reg;
        pc_next     = pc_reg;
        pop         = 1'b0;
        case (state_reg)
            S_IDLE: begin
                onehot_next = '0;
                valid_next  = 1'b0;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    onehot_next = head_onehot;
                    valid_next  = 1'b1;
                    hcnt_next   = HOLD_LOAD;
                    state_next  = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (hcnt_reg != '0) begin
                    hcnt_next = hcnt_reg - CNT_W'(1);
                end else begin
                    // Window complete.
                    pc_next = pc_reg + 8'd1;
                    if (GAP > 0) begin
                        onehot_next = '0;
                        valid_next  = 1'b0;
                        hcnt_next   = GAP_LOAD;
                        state_next  = S_GAP;
                    end else if (!fifo_empty) begin
                        // Back-to-back window: out_valid never drops.
                        pop         = 1'b1;
                        onehot_next = head_onehot;
                        hcnt_next   = HOLD_LOAD;
                    end else begin
                        onehot_next = '0;
                        valid_next  = 1'b0;
                        state_next  = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                onehot_next = '0;
                valid_next  = 1'b0;
                if (hcnt_reg != '0) begin
                    hcnt_next = hcnt_reg - CNT_W'(1);
                end else if (!fifo_empty) begin
                    pop         = 1'b1;
                    onehot_next = head_onehot;
                    valid_next  = 1'b1;
                    hcnt_next   = HOLD_LOAD;
                    state_next  = S_DRIVE;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                onehot_next = '0;
                valid_next  = 1'b0;
                state_next  = S_IDLE;
            end
        endcase
    end

    assign out_onehot  = onehot_reg;
    assign out_valid   = valid_reg;
    assign pulse_count = pc_reg;
    assign busy        = (state_reg != S_IDLE) || !fifo_empty;

endmodule
